// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI constants for the round-robin AXI read arbiter.
package axi_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Round-robin priority select: first eligible requester at or after ptr, wrapping.
module axi_rr_picker #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk from the farthest offset to the nearest so the nearest eligible wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (eligible[(int'(ptr) + k) % N]) begin
        grant                      = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx                        = PW'((int'(ptr) + k) % N);
        any                        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port among NUM_REQ requesters.
// Optional per-requester grant counters when AXI_RD_ARB_PERF_EN is defined.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3,
  parameter int MAX_OUTST = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [ID_W-1:0]           m_arid,
  output logic [2:0]                m_arsize,
  output logic [1:0]                m_arburst,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rlast,
  input  logic [ID_W-1:0]           m_rid,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_last,
`ifdef AXI_RD_ARB_PERF_EN
  output logic [NUM_REQ*16-1:0]     grant_cnt,
`endif
  output logic                      err_unexp
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST + 1);

  arb_state_t           state, state_nxt;
  logic [PW-1:0]        ptr;
  logic [CW-1:0]        outst [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible, pick_grant;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 ar_hs;
  logic                 r_hit;
  logic [PW-1:0]        r_sel;
  logic [NUM_REQ-1:0]   cnt_inc, cnt_dec;

  assign m_arsize  = axi_size(DATA_W);
  assign m_arburst = AXI_BURST_INCR;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (outst[i] != CW'(MAX_OUTST));
  end

  axi_rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    m_arvalid = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ar_hs = m_arvalid && m_arready;

  // AR payload is captured at grant and held untouched until the handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr      <= '0;
      m_araddr <= '0;
      m_arlen  <= '0;
      m_arid   <= '0;
    end else if (state == IDLE && pick_any) begin
      m_araddr <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      m_arlen  <= req_len[int'(pick_idx)*8 +: 8];
      m_arid   <= ID_W'(pick_idx);
    end else if (ar_hs) begin
      ptr <= (m_arid == ID_W'(NUM_REQ - 1)) ? '0 : PW'(m_arid + 1'b1);
    end
  end

  // A beat belongs to a requester only if its ID is in range and has a burst in flight.
  always_comb begin
    r_hit     = 1'b0;
    r_sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (m_rid == ID_W'(i) && outst[i] != '0) begin
        r_hit = 1'b1;
        r_sel = PW'(i);
      end
    end
    rsp_valid = '0;
    m_rready  = 1'b1;
    if (r_hit) begin
      rsp_valid[r_sel] = m_rvalid;
      m_rready         = rsp_ready[r_sel];
    end
  end

  assign rsp_data = m_rdata;
  assign rsp_resp = m_rresp;
  assign rsp_last = m_rlast;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = ar_hs && (m_arid == ID_W'(i));
      cnt_dec[i] = m_rvalid && m_rready && m_rlast && r_hit && (r_sel == PW'(i));
    end
  end

  // NOTE: the counter array is reset explicitly; eligibility reads it on the first cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) outst[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      outst[i] <= outst[i] + 1'b1;
        else if (!cnt_inc[i] && cnt_dec[i]) outst[i] <= outst[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)                  err_unexp <= 1'b0;
    else if (m_rvalid && !r_hit) err_unexp <= 1'b1;
  end

`ifdef AXI_RD_ARB_PERF_EN
  logic [15:0] perf_cnt [NUM_REQ];

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) perf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (cnt_inc[i] && perf_cnt[i] != 16'hFFFF) perf_cnt[i] <= perf_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = perf_cnt[i];
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized and directed bench for axi_rd_arbiter against a behavioural model.
module tb_axi_rd_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 3;
  localparam int MAX_OUTST = 4;

  logic                      aclk = 1'b0;
  logic                      areset;
  logic [NUM_REQ-1:0]        req_valid, req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_len;
  logic                      m_arvalid, m_arready;
  logic [ADDR_W-1:0]         m_araddr;
  logic [7:0]                m_arlen;
  logic [ID_W-1:0]           m_arid;
  logic [2:0]                m_arsize;
  logic [1:0]                m_arburst;
  logic                      m_rvalid, m_rready;
  logic [DATA_W-1:0]         m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rlast;
  logic [ID_W-1:0]           m_rid;
  logic [NUM_REQ-1:0]        rsp_valid, rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [1:0]                rsp_resp;
  logic                      rsp_last;
  logic                      err_unexp;
`ifdef AXI_RD_ARB_PERF_EN
  logic [NUM_REQ*16-1:0]     grant_cnt;
`endif

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arid(m_arid), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .rsp_last(rsp_last),
`ifdef AXI_RD_ARB_PERF_EN
    .grant_cnt(grant_cnt),
`endif
    .err_unexp(err_unexp)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: outstanding burst counts, one pending AR, rotating priority.
  int          mcnt [NUM_REQ];
  int          mperf[NUM_REQ];
  bit          mpend;
  int          mid;
  logic [31:0] maddr;
  logic [7:0]  mlen;
  int          mptr;
  bit          merr;
  int          ar_log[$];
  int          ar_cyc[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_pick();
    for (int k = 0; k < NUM_REQ; k++) begin
      int j = (mptr + k) % NUM_REQ;
      if (req_valid[j] && mcnt[j] < MAX_OUTST) return j;
    end
    return -1;
  endfunction

  function automatic bit model_hit();
    int r = int'(m_rid);
    if (r >= NUM_REQ) return 1'b0;
    return mcnt[r] > 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      mcnt[i]  = 0;
      mperf[i] = 0;
    end
    mpend = 1'b0; mid = 0; maddr = '0; mlen = '0; mptr = 0; merr = 1'b0;
  endtask

  // Compare every DUT output with the model, after inputs have settled.
  task automatic settle();
    int          p;
    bit          h;
    logic [3:0]  exp_rr, exp_rv;
    logic        exp_rrdy;
    #1;
    if (areset) return;
    p      = model_pick();
    h      = model_hit();
    exp_rr = (!mpend && p >= 0) ? 4'(1 << p) : 4'b0;
    exp_rv = (h && m_rvalid) ? 4'(1 << int'(m_rid)) : 4'b0;
    exp_rrdy = h ? rsp_ready[int'(m_rid) % NUM_REQ] : 1'b1;
    check("req_ready", req_ready, exp_rr);
    check("m_arvalid", m_arvalid, mpend);
    check("m_araddr", m_araddr, maddr);
    check("m_arlen", m_arlen, mlen);
    check("m_arid", m_arid, 3'(mid));
    check("m_arsize", m_arsize, 3'd2);
    check("m_arburst", m_arburst, 2'b01);
    check("rsp_valid", rsp_valid, exp_rv);
    check("m_rready", m_rready, exp_rrdy);
    if (exp_rv != 0) begin
      check("rsp_data", rsp_data, m_rdata);
      check("rsp_resp", rsp_resp, m_rresp);
      check("rsp_last", rsp_last, m_rlast);
    end
    check("err_unexp", err_unexp, merr);
`ifdef AXI_RD_ARB_PERF_EN
    for (int i = 0; i < NUM_REQ; i++) check("grant_cnt", grant_cnt[i*16 +: 16], 16'(mperf[i]));
`endif
  endtask

  // Advance one clock; model consumes the same inputs the DUT sampled.
  task automatic tick();
    int p;
    bit h;
    @(posedge aclk);
    cyc++;
    if (areset) begin
      model_reset();
    end else begin
      p = model_pick();
      h = model_hit();
      if (!mpend) begin
        if (p >= 0) begin
          mpend = 1'b1; mid = p;
          maddr = req_addr[p*ADDR_W +: ADDR_W];
          mlen  = req_len[p*8 +: 8];
        end
      end else if (m_arready) begin
        mcnt[mid]++;
        if (mperf[mid] < 16'hFFFF) mperf[mid]++;
        mptr = (mid + 1) % NUM_REQ;
        mpend = 1'b0;
        ar_log.push_back(mid);
        ar_cyc.push_back(cyc);
      end
      if (m_rvalid && h && rsp_ready[int'(m_rid)] && m_rlast) mcnt[int'(m_rid)]--;
      if (m_rvalid && !h) merr = 1'b1;
    end
    @(negedge aclk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0; rsp_ready = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_inputs();
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    int exp_ids[5];
    int beat;
    bit rdy[5];
    exp_ids = '{0, 1, 2, 3, 0};
    rdy     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    model_reset();
    @(negedge aclk);
    do_reset();

    // Reset state
    settle();
    check("rst_arvalid", m_arvalid, 1'b0);
    check("rst_araddr", m_araddr, 32'h0);
    check("rst_err", err_unexp, 1'b0);
    tick();

    // All four request together: IDs rotate 0,1,2,3,0, two cycles apart
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*32 +: 32] = 32'(32'h1000 * (i + 1));
      req_len[i*8 +: 8]    = 8'(i);
    end
    req_valid = 4'hF; m_arready = 1'b1;
    ar_log.delete(); ar_cyc.delete();
    for (int n = 0; n < 10; n++) cycle();
    check("rr_count", ar_log.size(), 5);
    for (int n = 0; n < 5 && n < ar_log.size(); n++) begin
      check("rr_id", ar_log[n], exp_ids[n]);
      if (n > 0) check("rr_gap", ar_cyc[n] - ar_cyc[n-1], 2);
    end

    // Outstanding limit on requester 1, released by one RLAST
    do_reset();
    req_valid = 4'b0010; m_arready = 1'b1;
    for (int n = 0; n < 8; n++) cycle();
    req_valid = 4'b0110;
    settle();
    check("limit_skip", req_ready, 4'b0100);
    tick();
    m_rvalid = 1'b1; m_rid = 3'd1; m_rlast = 1'b1; rsp_ready = 4'b0010;
    settle();
    check("limit_rvalid", rsp_valid, 4'b0010);
    check("limit_rready", m_rready, 1'b1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = '0; req_valid = 4'b0010;
    settle();
    check("limit_release", req_ready, 4'b0010);
    tick();

    // AR payload held while m_arready is low
    do_reset();
    req_valid = 4'b0001; req_addr[31:0] = 32'hABCD_0000; req_len[7:0] = 8'h0F;
    cycle();
    req_valid = '0; req_addr[31:0] = 32'h1234_5678; req_len[7:0] = 8'h01;
    for (int n = 0; n < 5; n++) begin
      settle();
      check("hold_arvalid", m_arvalid, 1'b1);
      check("hold_araddr", m_araddr, 32'hABCD_0000);
      check("hold_arlen", m_arlen, 8'h0F);
      check("hold_arid", m_arid, 3'd0);
      tick();
    end
    m_arready = 1'b1;
    cycle();

    // Reset while in ISSUE drops the pending AR and the outstanding counts
    m_arready = 1'b0; req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    settle();
    check("pre_rst_arvalid", m_arvalid, 1'b1);
    tick();
    do_reset();
    settle();
    check("post_rst_arvalid", m_arvalid, 1'b0);
    check("post_rst_req_ready", req_ready, 4'b0000);
`ifdef AXI_RD_ARB_PERF_EN
    check("post_rst_grant_cnt", grant_cnt, 64'h0);
`endif
    tick();
    m_rvalid = 1'b1; m_rid = 3'd0; rsp_ready = 4'b0000;
    settle();
    check("post_rst_drain", m_rready, 1'b1);
    check("post_rst_nosteer", rsp_valid, 4'b0000);
    tick();
    m_rvalid = 1'b0;

    // Four-beat burst for requester 2 with rsp_ready 1,0,1,1,1
    do_reset();
    req_valid = 4'b0100; m_arready = 1'b1;
    cycle();
    cycle();
    req_valid = '0;
    beat = 0;
    for (int k = 0; k < 5; k++) begin
      m_rvalid = 1'b1; m_rid = 3'd2; m_rdata = $urandom; m_rresp = 2'b00;
      m_rlast = (beat == 3); rsp_ready = rdy[k] ? 4'b0100 : 4'b0000;
      settle();
      check("burst_rsp_valid", rsp_valid, 4'b0100);
      check("burst_rready", m_rready, rdy[k]);
      check("burst_last", rsp_last, beat == 3);
      tick();
      if (rdy[k]) beat++;
    end
    check("burst_beats", beat, 4);
    m_rvalid = 1'b0; m_rlast = 1'b0; rsp_ready = '0;
    cycle();

    // Unknown RID 5: drained, not steered, sticky error until reset
    m_rvalid = 1'b1; m_rid = 3'd5; rsp_ready = 4'b0000;
    settle();
    check("unexp_rready", m_rready, 1'b1);
    check("unexp_rsp_valid", rsp_valid, 4'b0000);
    tick();
    m_rvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      settle();
      check("unexp_sticky", err_unexp, 1'b1);
      tick();
    end
    do_reset();
    settle();
    check("unexp_cleared", err_unexp, 1'b0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      int cand[$];
      areset    = ($urandom_range(399) == 0);
      req_valid = 4'($urandom);
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      req_len   = $urandom;
      m_arready = ($urandom_range(9) < 6);
      m_rvalid  = $urandom_range(1) == 1;
      m_rdata   = $urandom;
      m_rresp   = 2'($urandom);
      m_rlast   = ($urandom_range(9) < 4);
      rsp_ready = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) if (mcnt[i] > 0) cand.push_back(i);
      if ($urandom_range(19) == 0)                 m_rid = 3'(4 + $urandom_range(3));
      else if (cand.size() > 0 && $urandom_range(9) != 0)
        m_rid = 3'(cand[$urandom_range(cand.size() - 1)]);
      else                                         m_rid = 3'($urandom_range(3));
      if (n % 500 == 499) areset = 1'b1;
      cycle();
    end
    areset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Round-robin read arbiter that shares one AXI4 master read port (AR/R channels) among NUM_REQ simple read requesters. It sits between local read clients and the AXI VIP/interconnect slave side. It tags each AR burst with the requester index as ARID, limits outstanding bursts per requester, and steers returning R beats back to the owner by RID.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 32: address width
- DATA_W, 32: data width, power of two, 8..1024
- ID_W, 3: AXI ID width; must satisfy 2**ID_W >= NUM_REQ
- MAX_OUTST, 4: max outstanding bursts per requester, 1..15

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_ready  out  NUM_REQ  request accepted; one-hot or zero
- req_addr  in  NUM_REQ*ADDR_W  start address, requester i at slice i
- req_len  in  NUM_REQ*8  AXI ARLEN (beats-1), slice i
- m_arvalid / m_arready  out / in  1  AR handshake
- m_araddr  out  ADDR_W; m_arlen  out  8; m_arid  out  ID_W
- m_arsize  out  3  constant clog2(DATA_W/8); m_arburst  out  2  constant INCR (2'b01)
- m_rvalid / m_rready  in / out  1  R handshake
- m_rdata  in  DATA_W; m_rresp  in  2; m_rlast  in  1; m_rid  in  ID_W
- rsp_valid  out  NUM_REQ  beat for requester i
- rsp_ready  in  NUM_REQ  requester i accepts beat
- rsp_data  out  DATA_W; rsp_resp  out  2; rsp_last  out  1  shared, qualified by rsp_valid
- err_unexp  out  1  sticky: R beat with unknown/idle RID

## Operation
- FSM states IDLE, ISSUE. Reset: IDLE, rr pointer 0, all outstanding counters 0, m_arvalid 0, m_araddr/m_arlen/m_arid 0, req_ready 0, err_unexp 0.
- IDLE: eligible = req_valid & ~(outst[i]==MAX_OUTST). If any eligible, pick first eligible at or after pointer (wrapping); assert req_ready[pick] combinationally that cycle; register addr/len/id=pick; next state ISSUE.
- ISSUE: m_arvalid=1, AR payload held stable until m_arready. On handshake: outst[id]++, pointer=(id+1) mod NUM_REQ, next state IDLE. No req_ready in ISSUE.
- R routing (combinational): if m_rid<NUM_REQ and outst[m_rid]!=0: rsp_valid[m_rid]=m_rvalid, m_rready=rsp_ready[m_rid]; rsp_data/resp/last = m_rdata/rresp/rlast.
- Unknown RID (>=NUM_REQ or counter 0): m_rready=1 (drain), no rsp_valid, err_unexp set on m_rvalid; cleared only by reset.
- On R handshake with m_rlast for a valid RID: outst[rid]--.
- Same-cycle AR handshake and last-beat retire on the same ID: counter unchanged.
- Counters width clog2(MAX_OUTST+1); never wrap (eligibility gate prevents overflow, unknown-RID check prevents underflow).
- Reset mid-burst: all state dropped; downstream slave must be reset concurrently.

## Timing
- Request accepted in cycle N (IDLE) -> m_arvalid high from N+1; with m_arready=1 at N+1, next grant possible at N+2. Peak rate one AR per 2 cycles.
- R path has zero latency, no buffering; m_rready depends combinationally on rsp_ready.
- m_arvalid never deasserts without handshake (AXI rule).

## Configuration
- AXI_RD_ARB_PERF_EN defined: adds output grant_cnt (NUM_REQ*16), per-requester AR-handshake counters, saturating at 16'hFFFF, zero on reset.
- Undefined: port and counters absent; behaviour otherwise identical.

## Structure
- Package axi_rd_arb_pkg: state enum typedef (IDLE, ISSUE), AXI_BURST_INCR, AXI_RESP_OKAY/SLVERR/DECERR constants, size function clog2(DATA_W/8).
- Sub-module axi_rr_picker: NUM_REQ-wide round-robin priority select (eligible, pointer -> one-hot grant, index, any).

## Test plan
- All 4 requesters assert req_valid together, m_arready=1 -> ARIDs issued 0,1,2,3,0 in successive grants, each 2 cycles apart.
- Requester 1 issues 4 bursts, no R returned, MAX_OUTST=4 -> 5th request held (req_ready[1]=0) while requester 2 still granted; one RLAST on RID=1 -> requester 1 granted next.
- m_arready low for 5 cycles in ISSUE -> m_araddr/m_arlen/m_arid stable, m_arvalid held high throughout.
- R beats RID=2, len=3, rsp_ready[2] toggled 1,0,1,1,1 -> 4 beats delivered to requester 2 only, m_rready follows rsp_ready[2], outst[2] decrements on beat 4.
- R beat with RID=5 (NUM_REQ=4) -> m_rready=1, no rsp_valid, err_unexp=1 until areset.
- areset asserted in ISSUE -> next cycle m_arvalid=0, counters 0; with PERF_EN, grant_cnt=0.
